systolic_deskew_buffer: RTL

- Receives skewed accumulator output from the systolic array. Column c of a result row arrives c cycles after column 0.
- Re-aligns the columns into whole rows and queues them in a small row FIFO.
- Presents rows downstream on a valid/ready interface.
- Drives a stall signal back to the array so no row is lost. This is the receive-side counterpart of the input skew staging.

---
 rtl/systolic_deskew_buffer_if.sv | 29 ++
 rtl/systolic_deskew_buffer.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/systolic_deskew_buffer_if.sv
// Array-to-deskew and deskew-to-consumer signal bundle.
//   in_valid  : column 0 of a new row is on in_data this cycle
//   in_data   : skewed accumulator columns, column c at [acc_width*(c+1)-1 : acc_width*c]
//   stall     : array must hold off new rows while high
//   out_valid : an aligned row is presented on out_data
//   out_ready : consumer accepts the presented row
//   out_data  : aligned row, same column packing as in_data
// master = array/consumer side, slave = deskew buffer side.
interface systolic_deskew_buffer_if #(
  parameter int acc_width       = 8,
  parameter int systolic_column = 16
);
  logic                                 in_valid;
  logic [acc_width*systolic_column-1:0] in_data;
  logic                                 stall;
  logic                                 out_valid;
  logic                                 out_ready;
  logic [acc_width*systolic_column-1:0] out_data;

  modport master (
    output in_valid, in_data, out_ready,
    input  stall, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output stall, out_valid, out_data
  );
endinterface

// File: rtl/systolic_deskew_buffer.sv
// Receive-side deskew for the systolic array. Column c of a result row
// arrives c cycles after column 0; each column is delayed so that all
// columns line up, and whole rows are queued in a small circular FIFO that
// is drained over a valid/ready handshake. A stall estimate (queued rows
// plus rows still in the alignment chain) tells the array when to stop.
// Ports:
//   clk, rst_n  : rising-edge clock, asynchronous active-low reset
//   bus         : in_valid/in_data/stall (array side) and
//                 out_valid/out_ready/out_data (consumer side)
//   overflow    : sticky flag, row issued during stall or row dropped
//   row_count   : rows popped since reset, wraps at 2^16
module systolic_deskew_buffer #(
  parameter int acc_width       = 8,
  parameter int systolic_column = 16,
  parameter int fifo_depth      = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  systolic_deskew_buffer_if.slave   bus,
  output logic                      overflow,
  output logic [15:0]               row_count
);

  localparam int ROW_W = acc_width * systolic_column;
  localparam int VSR_W = systolic_column - 1;
  localparam int PTR_W = $clog2(fifo_depth);
  localparam int CNT_W = PTR_W + 1;
  // Wide enough for fifo_depth + (systolic_column - 1).
  localparam int SUM_W = $clog2(fifo_depth + systolic_column) + 1;

  logic [VSR_W-1:0] vsr_r;
  logic [ROW_W-1:0] aligned_s;
  logic [ROW_W-1:0] mem_r [fifo_depth];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic             overflow_r;
  logic [15:0]      row_count_r;

  logic push_s;
  logic pop_s;
  logic full_s;
  logic accept_s;
  logic drop_s;
  logic stall_s;
  logic violate_s;

  // Number of rows currently travelling through the alignment chain.
  function automatic logic [SUM_W-1:0] popcount(input logic [VSR_W-1:0] v);
    logic [SUM_W-1:0] n;
    n = '0;
    for (int i = 0; i < VSR_W; i++) begin
      n = n + SUM_W'(v[i]);
    end
    return n;
  endfunction

  // Column c is delayed by (systolic_column-1-c) registers; the last column
  // arrives already aligned and passes straight through.
  for (genvar c = 0; c < systolic_column; c++) begin : g_col
    localparam int DEPTH = systolic_column - 1 - c;
    if (DEPTH == 0) begin : g_pass
      assign aligned_s[acc_width*c +: acc_width] = bus.in_data[acc_width*c +: acc_width];
    end else begin : g_dly
      logic [acc_width-1:0] dly_r [DEPTH];

      // Per-column delay line; data is taken every cycle, qualification comes from vsr_r.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int k = 0; k < DEPTH; k++) begin
            dly_r[k] <= '0;
          end
        end else begin
          dly_r[0] <= bus.in_data[acc_width*c +: acc_width];
          for (int k = 1; k < DEPTH; k++) begin
            dly_r[k] <= dly_r[k-1];
          end
        end
      end

      assign aligned_s[acc_width*c +: acc_width] = dly_r[DEPTH-1];
    end
  end

  // The top vsr bit marks the cycle in which a whole aligned row sits at the chain outputs.
  assign push_s    = vsr_r[VSR_W-1];
  assign pop_s     = (count_r != '0) && bus.out_ready;
  assign full_s    = (count_r == CNT_W'(fifo_depth));
  // A full FIFO still takes the row when the head leaves in the same cycle.
  assign accept_s  = push_s && (!full_s || pop_s);
  assign drop_s    = push_s && full_s && !pop_s;
  assign stall_s   = (SUM_W'(count_r) + popcount(vsr_r)) >= SUM_W'(fifo_depth);
  assign violate_s = bus.in_valid && stall_s;

  assign bus.stall     = stall_s;
  assign bus.out_valid = (count_r != '0);
  assign bus.out_data  = mem_r[rd_ptr_r];
  assign overflow      = overflow_r;
  assign row_count     = row_count_r;

  // Valid chain: shifts in_valid alongside the column-0 delay line.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vsr_r <= '0;
    end else begin
      vsr_r <= (vsr_r << 1) | VSR_W'(bus.in_valid);
    end
  end

  // Row FIFO storage, pointers and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < fifo_depth; i++) begin
        mem_r[i] <= '0;
      end
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (accept_s) begin
        mem_r[wr_ptr_r] <= aligned_s;
        wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      case ({accept_s, pop_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Sticky protocol-violation / dropped-row flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow_r <= 1'b0;
    end else if (violate_s || drop_s) begin
      overflow_r <= 1'b1;
    end else begin
      overflow_r <= overflow_r;
    end
  end

  // Count of rows handed downstream.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_count_r <= 16'd0;
    end else if (pop_s) begin
      row_count_r <= row_count_r + 16'd1;
    end else begin
      row_count_r <= row_count_r;
    end
  end

endmodule
